// File: rtl/mux_src_arbiter.sv
// Two-channel valid/ready feeder for the 2:1 datapath mux: one holding word per
// channel, round-robin grant, registered mux inputs and per-channel delivery counters.
module mux_src_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in2_valid,
    output logic              in2_ready,
    input  logic [DATA_W-1:0] in2_data,
    output logic [DATA_W-1:0] mux_in1,
    output logic [DATA_W-1:0] mux_in2,
    output logic              mux_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt1,
    output logic [CNT_W-1:0]  xfer_cnt2
);

    typedef enum logic {
        PRI1 = 1'b0,
        PRI2 = 1'b1
    } rr_state_e;

    rr_state_e         rr_q, rr_d;
    logic              hold1_v_q, hold1_v_d;
    logic              hold2_v_q, hold2_v_d;
    logic [DATA_W-1:0] hold1_data_q, hold1_data_d;
    logic [DATA_W-1:0] hold2_data_q, hold2_data_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic [CNT_W-1:0]  cnt2_q, cnt2_d;

    logic any_valid;
    logic grant2;
    logic deliver;
    logic dlv1;
    logic dlv2;
    logic rdy1;
    logic rdy2;
    logic xfer1;
    logic xfer2;

    // Grant depends only on registered state, so the mux select and the
    // granted word cannot move while the downstream is stalling.
    always_comb begin
        any_valid = hold1_v_q | hold2_v_q;
        grant2    = hold2_v_q & (~hold1_v_q | (rr_q == PRI2));
        deliver   = any_valid & out_ready;
        dlv1      = deliver & ~grant2;
        dlv2      = deliver & grant2;
        rdy1      = ~hold1_v_q | (~grant2 & out_ready);
        rdy2      = ~hold2_v_q | (grant2 & out_ready);
        xfer1     = in1_valid & rdy1;
        xfer2     = in2_valid & rdy2;
    end

    // A refill in the same cycle as a delivery wins, keeping the slot full.
    always_comb begin
        hold1_v_d    = hold1_v_q;
        hold2_v_d    = hold2_v_q;
        hold1_data_d = hold1_data_q;
        hold2_data_d = hold2_data_q;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;

        if (dlv1) begin
            hold1_v_d = 1'b0;
            cnt1_d    = cnt1_q + CNT_W'(1);
        end
        if (dlv2) begin
            hold2_v_d = 1'b0;
            cnt2_d    = cnt2_q + CNT_W'(1);
        end
        if (xfer1) begin
            hold1_v_d    = 1'b1;
            hold1_data_d = in1_data;
        end
        if (xfer2) begin
            hold2_v_d    = 1'b1;
            hold2_data_d = in2_data;
        end
    end

    // Priority only moves on deliveries, never on input transfers.
    always_comb begin
        rr_d = rr_q;
        unique case (rr_q)
            PRI1: if (dlv1) rr_d = PRI2;
            PRI2: if (dlv2) rr_d = PRI1;
            default: rr_d = PRI1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= PRI1;
            hold1_v_q    <= 1'b0;
            hold2_v_q    <= 1'b0;
            hold1_data_q <= '0;
            hold2_data_q <= '0;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
        end else begin
            rr_q         <= rr_d;
            hold1_v_q    <= hold1_v_d;
            hold2_v_q    <= hold2_v_d;
            hold1_data_q <= hold1_data_d;
            hold2_data_q <= hold2_data_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
        end
    end

    assign in1_ready = rdy1;
    assign in2_ready = rdy2;
    assign mux_in1   = hold1_data_q;
    assign mux_in2   = hold2_data_q;
    assign mux_sel   = grant2;
    assign out_valid = any_valid;
    assign xfer_cnt1 = cnt1_q;
    assign xfer_cnt2 = cnt2_q;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Scoreboard bench for mux_src_arbiter: a queue-based reference model predicts
// deliveries and port values; a negedge monitor compares the DUT against it.
module tb_mux_src_arbiter;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in1_valid = 1'b0, in2_valid = 1'b0;
    logic [DW-1:0] in1_data = '0, in2_data = '0;
    logic          in1_ready, in2_ready;
    logic [DW-1:0] mux_in1, mux_in2;
    logic          mux_sel, out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] xfer_cnt1, xfer_cnt2;

    always #5 clk = ~clk;

    mux_src_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
        .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
        .mux_in1(mux_in1), .mux_in2(mux_in2), .mux_sel(mux_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .xfer_cnt1(xfer_cnt1), .xfer_cnt2(xfer_cnt2)
    );

    typedef struct {
        int            ch;
        logic [DW-1:0] word;
    } dlv_t;

    // Reference model: each channel is a queue of depth <= 1; the preferred
    // channel is whichever one was not served last.
    logic [DW-1:0] slot1[$];
    logic [DW-1:0] slot2[$];
    dlv_t          exp_q[$];
    int            last_srv;
    logic [DW-1:0] m_data1, m_data2;
    logic [CW-1:0] m_cnt1, m_cnt2;
    logic          m_acc1, m_acc2;
    logic          mon_en = 1'b0;

    logic          e_ov, e_sel, e_r1, e_r2;
    logic [DW-1:0] e_in1, e_in2;
    logic [CW-1:0] e_c1, e_c2;

    int   checks = 0;
    int   failures = 0;
    dlv_t mon_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        slot1.delete();
        slot2.delete();
        exp_q.delete();
        last_srv = 2;
        m_data1  = '0;
        m_data2  = '0;
        m_cnt1   = '0;
        m_cnt2   = '0;
        mon_en   = 1'b0;
    endtask

    // One clock of stimulus: drive inputs just after the edge, predict what the
    // DUT shows this cycle, then advance the model past the next edge.
    task automatic cycle(input logic v1, input logic [DW-1:0] d1,
                         input logic v2, input logic [DW-1:0] d2, input logic ordy);
        logic n1, n2;
        int   g;
        dlv_t t;
        @(posedge clk);
        #1;
        in1_valid = v1; in1_data = d1;
        in2_valid = v2; in2_data = d2;
        out_ready = ordy;
        n1 = (slot1.size() > 0);
        n2 = (slot2.size() > 0);
        g  = (n1 && n2) ? ((last_srv == 1) ? 2 : 1) : (n2 ? 2 : 1);
        e_ov  = n1 || n2;
        e_sel = (g == 2);
        e_r1  = !n1 || (g == 1 && ordy);
        e_r2  = !n2 || (g == 2 && ordy);
        e_in1 = m_data1;
        e_in2 = m_data2;
        e_c1  = m_cnt1;
        e_c2  = m_cnt2;
        if (e_ov && ordy) begin
            t.ch = g;
            if (g == 1) begin
                t.word = slot1.pop_front();
                m_cnt1 = m_cnt1 + 1'b1;
            end else begin
                t.word = slot2.pop_front();
                m_cnt2 = m_cnt2 + 1'b1;
            end
            exp_q.push_back(t);
            last_srv = g;
        end
        m_acc1 = v1 && e_r1;
        m_acc2 = v2 && e_r2;
        if (m_acc1) begin slot1.push_back(d1); m_data1 = d1; end
        if (m_acc2) begin slot2.push_back(d2); m_data2 = d2; end
        mon_en = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_in1_ready", in1_ready, 1);
        chk("rst_in2_ready", in2_ready, 1);
        chk("rst_cnt1", xfer_cnt1, 0);
        chk("rst_cnt2", xfer_cnt2, 0);
        chk("rst_mux_in1", mux_in1, 0);
        chk("rst_mux_in2", mux_in2, 0);
        model_reset();
        in1_valid = 1'b0; in2_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("out_valid", out_valid, e_ov);
            chk("mux_sel", mux_sel, e_sel);
            chk("in1_ready", in1_ready, e_r1);
            chk("in2_ready", in2_ready, e_r2);
            chk("mux_in1", mux_in1, e_in1);
            chk("mux_in2", mux_in2, e_in2);
            chk("xfer_cnt1", xfer_cnt1, e_c1);
            chk("xfer_cnt2", xfer_cnt2, e_c2);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_delivery actual=sel%0d required=none", mux_sel);
                end else begin
                    mon_t = exp_q.pop_front();
                    chk("dlv_channel", mux_sel, (mon_t.ch == 2));
                    chk("dlv_word", mux_sel ? mux_in2 : mux_in1, mon_t.word);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int k1, k2;
        logic p1, p2;
        logic [DW-1:0] pd1, pd2;

        model_reset();
        #2;
        do_reset();

        // ch1-only stream
        for (int k = 1; k <= 4; k++) cycle(1'b1, 32'hA000_0000 | k, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("stream_cnt1", xfer_cnt1, 4);

        // both channels always valid, alternating grants
        k1 = 0; k2 = 0;
        repeat (16) begin
            cycle(1'b1, 32'h1111_0000 | k1, 1'b1, 32'h2222_0000 | k2, 1'b1);
            if (m_acc1) k1++;
            if (m_acc2) k2++;
        end

        // backpressure then release
        repeat (6) begin
            cycle(1'b1, 32'h1111_0000 | k1, 1'b1, 32'h2222_0000 | k2, 1'b0);
            if (m_acc1) k1++;
            if (m_acc2) k2++;
        end
        @(negedge clk);
        chk("bp_in1_ready", in1_ready, 0);
        chk("bp_in2_ready", in2_ready, 0);
        repeat (8) begin
            cycle(1'b1, 32'h1111_0000 | k1, 1'b1, 32'h2222_0000 | k2, 1'b1);
            if (m_acc1) k1++;
            if (m_acc2) k2++;
        end

        // reset in the middle of traffic
        @(posedge clk);
        #3;
        do_reset();

        // same-cycle delivery and refill of ch2
        cycle(1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0001, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("refill_mux_in2", mux_in2, 32'hDEAD_BEEF);
        chk("refill_out_valid", out_valid, 1);
        chk("refill_sel", mux_sel, 1);
        cycle(1'b1, 32'hCCCC_0001, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("refill_pri1_sel", mux_sel, 0);

        // randomized traffic, sources hold their word until accepted
        p1 = 1'b0; p2 = 1'b0; pd1 = '0; pd2 = '0;
        repeat (400) begin
            if (!p1 && ($urandom_range(0, 3) != 0)) begin p1 = 1'b1; pd1 = $urandom; end
            if (!p2 && ($urandom_range(0, 3) != 0)) begin p2 = 1'b1; pd2 = $urandom; end
            cycle(p1, pd1, p2, pd2, ($urandom_range(0, 2) != 0));
            if (m_acc1) p1 = 1'b0;
            if (m_acc2) p2 = 1'b0;
        end
        repeat (3) cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        // counter wrap
        @(posedge clk);
        #3;
        do_reset();
        for (int i = 0; i < 65535; i++) cycle(1'b1, i, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("wrap_cnt1_max", xfer_cnt1, 16'hFFFF);
        cycle(1'b1, 32'h5A5A_5A5A, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("wrap_cnt1_zero", xfer_cnt1, 0);
        chk("wrap_drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
